// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout and FSM encoding.
// Used by the float add/sub unit and by the float<->fixed converters.
package fp_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;

    localparam int         EXP_BIAS    = 127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_PACK   = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a single-precision word into fields and class flags.
// The mantissa output carries the hidden bit, so it is only meaningful for normals.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       data,
    output logic              sign,
    output logic [7:0]        exp,
    output logic [MANT_W:0]   mant,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [MANT_W-1:0] frac;

    assign sign    = data[SIGN_BIT];
    assign exp     = data[EXP_MSB:EXP_LSB];
    assign frac    = data[MANT_W-1:0];
    assign mant    = {1'b1, frac};

    // Subnormals are treated as zero.
    assign is_zero = (exp == 8'd0);
    assign is_inf  = (exp == EXP_SPECIAL) && (frac == '0);
    assign is_nan  = (exp == EXP_SPECIAL) && (frac != '0);

endmodule

// File: rtl/fp_to_fixed_serial.sv
// Float-to-fixed converter: decode, serial one-bit-per-cycle alignment,
// then saturating two's-complement pack, with valid/ready on both sides.
module fp_to_fixed_serial
    import fp_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_nan
);

    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    // k = e - (bias + mantissa width) + FRAC_BITS; overflow once the hidden bit passes OUT_W-2.
    localparam logic signed [9:0] K_OFFSET = 10'(FRAC_BITS - EXP_BIAS - MANT_W);
    localparam logic signed [9:0] K_MAX    = 10'(OUT_W - 1 - MANT_W);

    logic [2:0]       state;
    logic [31:0]      op;
    logic [OUT_W-1:0] mag;
    logic [9:0]       cnt;
    logic             dir_left;
    logic             sign_r;
    logic             pre_sat;
    logic             pre_nan;

    logic             u_sign;
    logic [7:0]       u_exp;
    logic [MANT_W:0]  u_mant;
    logic             u_zero;
    logic             u_inf;
    logic             u_nan;
    logic signed [9:0] k;
    logic [9:0]       k_abs;
    logic [OUT_W-1:0] mant_ext;

    fp_unpack unpack (
        .data    (op),
        .sign    (u_sign),
        .exp     (u_exp),
        .mant    (u_mant),
        .is_zero (u_zero),
        .is_inf  (u_inf),
        .is_nan  (u_nan)
    );

    assign k        = $signed({2'b00, u_exp}) + K_OFFSET;
    assign k_abs    = k[9] ? 10'(-k) : 10'(k);
    assign mant_ext = {{(OUT_W-MANT_W-1){1'b0}}, u_mant};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op       <= '0;
            mag      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
            sign_r   <= 1'b0;
            pre_sat  <= 1'b0;
            pre_nan  <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_nan  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op    <= in_data;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    sign_r  <= u_sign;
                    pre_sat <= 1'b0;
                    pre_nan <= 1'b0;
                    mag     <= '0;
                    cnt     <= '0;
                    state   <= ST_PACK;
                    if (u_zero) begin
                        sign_r <= 1'b0;
                    end else if (u_nan) begin
                        pre_sat <= 1'b1;
                        pre_nan <= 1'b1;
                    end else if (u_inf || (k > K_MAX)) begin
                        pre_sat <= 1'b1;
                    end else if (k > -10'sd24) begin
                        mag      <= mant_ext;
                        cnt      <= k_abs;
                        dir_left <= ~k[9];
                        if (k != 10'sd0) state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    mag <= dir_left ? (mag << 1) : (mag >> 1);
                    cnt <= cnt - 10'd1;
                    if (cnt == 10'd1) state <= ST_PACK;
                end
                ST_PACK: begin
                    // NaN always clamps positive; the MIN_NEG magnitude negates to itself.
                    if (pre_sat) begin
                        out_data <= (pre_nan || !sign_r) ? MAX_POS : MIN_NEG;
                        out_sat  <= 1'b1;
                        out_nan  <= pre_nan;
                    end else if (!sign_r && (mag > MAX_POS)) begin
                        out_data <= MAX_POS;
                        out_sat  <= 1'b1;
                        out_nan  <= 1'b0;
                    end else if (sign_r && (mag > MIN_NEG)) begin
                        out_data <= MIN_NEG;
                        out_sat  <= 1'b1;
                        out_nan  <= 1'b0;
                    end else begin
                        out_data <= sign_r ? (~mag + 1'b1) : mag;
                        out_sat  <= 1'b0;
                        out_nan  <= 1'b0;
                    end
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_fixed_serial.sv
// Self-checking bench for fp_to_fixed_serial (OUT_W=32, FRAC_BITS=16):
// directed vector table, backpressure and reset sequences, then random operands vs a real-arithmetic model.
module tb_fp_to_fixed_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        out_nan;

    int compared   = 0;
    int mismatched = 0;

    fp_to_fixed_serial #(.OUT_W(32), .FRAC_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] operand;
        logic [31:0] data;
        logic        sat;
        logic        nan;
        int          lat;
    } vec_t;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: value = mant * 2^(e-150) scaled by 2^16, truncated toward zero, saturated.
    // Latency counts edges from the accepting edge inclusive.
    task automatic model(input logic [31:0] x, output logic [31:0] d, output logic s,
                         output logic n, output int lat);
        int  e;
        int  k;
        real m;
        longint v;
        e   = int'(x[30:23]);
        k   = e - 150 + 16;
        s   = 1'b0;
        n   = 1'b0;
        lat = 3;
        d   = 32'h0;
        if (e == 0) begin
            d = 32'h0;
        end else if (e == 255) begin
            s = 1'b1;
            if (x[22:0] != 23'd0) begin
                n = 1'b1;
                d = 32'h7FFF_FFFF;
            end else begin
                d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            m = $floor(real'(32'h0080_0000 + int'(x[22:0])) * (2.0 ** real'(k)));
            if (k > -24 && k <= 8) lat = 3 + ((k < 0) ? -k : k);
            if (!x[31] && m > 2147483647.0) begin
                s = 1'b1;
                d = 32'h7FFF_FFFF;
            end else if (x[31] && m > 2147483648.0) begin
                s = 1'b1;
                d = 32'h8000_0000;
            end else begin
                v = longint'(m);
                if (x[31]) v = -v;
                d = v[31:0];
            end
        end
    endtask

    // Drives one operand, measures latency, holds out_ready low for 'hold' cycles, then handshakes.
    task automatic apply_stimulus(input logic [31:0] x, input int hold, input string tag,
                                  output logic [31:0] d, output logic s, output logic n, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check_output({tag, " in_ready_wait"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        d = out_data;
        s = out_sat;
        n = out_nan;
        if (!out_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: out_valid=0 after %0d edges, expected 1", tag, lat);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check_output({tag, " hold_data"}, 64'(out_data), 64'(d));
            check_output({tag, " hold_valid"}, 64'(out_valid), 64'd1);
            check_output({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, " post_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, " post_in_ready"}, 64'(in_ready), 64'd1);
        check_output({tag, " post_data_kept"}, 64'(out_data), 64'(d));
    endtask

    vec_t        vecs[$];
    logic [31:0] d;
    logic        s;
    logic        n;
    int          lat;
    logic [31:0] exp_d;
    logic        exp_s;
    logic        exp_n;
    int          exp_lat;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset in_ready", 64'(in_ready), 64'd1);
        check_output("reset out_valid", 64'(out_valid), 64'd0);
        check_output("reset out_data", 64'(out_data), 64'd0);
        check_output("reset out_sat", 64'(out_sat), 64'd0);
        check_output("reset out_nan", 64'(out_nan), 64'd0);

        vecs.push_back('{32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0, 10});
        vecs.push_back('{32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0, 9});
        vecs.push_back('{32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0, 11});
        vecs.push_back('{32'h471C_4000, 32'h7FFF_FFFF, 1'b1, 1'b0, 11});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 3});
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3});
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 3});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h3580_0000, 32'h0000_0000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3});
        vecs.push_back('{32'h4300_0000, 32'h0080_0000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'hBF80_0000, 32'hFFFF_0000, 1'b0, 1'b0, 10});
        vecs.push_back('{32'h3780_0000, 32'h0000_0001, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h3700_0000, 32'h0000_0000, 1'b0, 1'b0, 3});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].operand, 0, $sformatf("vec%0d", i), d, s, n, lat);
            check_output($sformatf("vec%0d data", i), 64'(d), 64'(vecs[i].data));
            check_output($sformatf("vec%0d sat", i), 64'(s), 64'(vecs[i].sat));
            check_output($sformatf("vec%0d nan", i), 64'(n), 64'(vecs[i].nan));
            check_output($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Backpressure on 1.0: result held for 5 cycles with in_valid pushed at the busy block.
        apply_stimulus(32'h3F80_0000, 5, "bp", d, s, n, lat);
        check_output("bp data", 64'(d), 64'h0001_0000);

        // Reset during SHIFT aborts the conversion.
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("abort in_ready", 64'(in_ready), 64'd1);
        check_output("abort out_valid", 64'(out_valid), 64'd0);
        check_output("abort out_data", 64'(out_data), 64'd0);
        apply_stimulus(32'h3F80_0000, 0, "after_abort", d, s, n, lat);
        check_output("after_abort data", 64'(d), 64'h0001_0000);
        check_output("after_abort latency", 64'(lat), 64'd10);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] x;
            x = $urandom;
            if (i % 4 != 0) x[30:23] = 8'($urandom_range(100, 175));
            model(x, exp_d, exp_s, exp_n, exp_lat);
            apply_stimulus(x, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i), d, s, n, lat);
            check_output($sformatf("rnd%0d data x=%08h", i, x), 64'(d), 64'(exp_d));
            check_output($sformatf("rnd%0d sat x=%08h", i, x), 64'(s), 64'(exp_s));
            check_output($sformatf("rnd%0d nan x=%08h", i, x), 64'(n), 64'(exp_n));
            check_output($sformatf("rnd%0d latency x=%08h", i, x), 64'(lat), 64'(exp_lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
